if_fetch_ctrl: RTL and testbench
================================

Name: if_fetch_ctrl

Overview:
- Instruction-fetch initiator that drives the read port of the 16-bit big-endian fetch memory.
- Holds the PC and issues one aligned 16-bit read per cycle. Captures the returned word into a small instruction queue and presents it to decode with a valid/ready handshake.
- Handles redirects from branches, halt, and misaligned-fetch errors reported by the memory.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- QDEPTH, 2, instruction queue depth. Must be a power of two and at least 2.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-low
- redirect_valid  in  1  load a new PC and flush the queue
- redirect_pc  in  16  target PC for a redirect
- halt  in  1  stop fetching (decode saw HALT)
- inst_ready  in  1  decode consumes the head entry this cycle
- inst_valid  out  1  queue head is valid
- inst_out  out  16  instruction word at the queue head
- inst_pc  out  16  PC of the queue head
- fetch_err  out  1  sticky misaligned-fetch error
- fetch_err_pc  out  16  PC that faulted
- mem_addr  out  16  memory address (equals pc)
- mem_enable  out  1  memory access enable
- mem_wr  out  1  memory write; tied 0
- mem_data_in  out  16  memory write data; tied 16'h0
- mem_data_out  in  16  memory read data; combinational, same cycle as the address
- mem_err  in  1  memory error: enable & addr[0]

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=RESET_PC, state=RUN, queue empty.
  - inst_valid=0, inst_out=0, inst_pc=0.
  - fetch_err=0, fetch_err_pc=0.
  - mem_enable=0, mem_wr=0, mem_data_in=0.
- State machine states: RUN, HALTED, ERR.
- Fetch condition, evaluated combinationally each cycle. A fetch occurs when all of the following hold:
  - state==RUN;
  - redirect_valid=0;
  - the queue has a slot, i.e. count<QDEPTH, or count==QDEPTH with inst_ready & inst_valid this cycle.
- While the fetch condition holds: mem_enable=1 and mem_addr=pc.
  - Otherwise mem_enable=0, mem_addr holds pc.
- Fetch success (mem_err=0): at the rising edge, enqueue {mem_data_out, pc} and set pc <= pc+2.
  - PC arithmetic is modulo 2^16: 16'hFFFE wraps to 16'h0000.
- Fetch fault (mem_err=1):
  - No enqueue, pc unchanged, state goes to ERR.
  - fetch_err <= 1, fetch_err_pc <= pc.
  - Queue contents ahead of the fault remain drainable.
- Dequeue: when inst_ready & inst_valid, pop the head at the edge. Simultaneous enqueue and dequeue is allowed at any occupancy, including full.
- Latency: a word fetched in cycle N is visible at inst_out in cycle N+1.
- inst_out and inst_pc are 0 whenever inst_valid=0.
- halt=1 in RUN (with no redirect): go to HALTED at the edge. A fetch in that same cycle still completes; the queue is kept.
- redirect_valid=1 (in any state):
  - Queue flushed, pc <= redirect_pc, state <= RUN.
  - fetch_err is cleared; fetch_err_pc holds its value.
  - No fetch occurs that cycle. A dequeue that same cycle is discarded.
  - Redirect has priority over halt, fetch and dequeue.
- An odd redirect_pc is accepted. The next fetch then faults through mem_err, which is the only alignment check.
- ERR and HALTED are exited only by redirect or by reset.
- rst asserted mid-operation: everything returns to reset values immediately; in-flight data is lost.

Optional Feature:
- Macro: IF_BYPASS_EN.
- Defined: when the queue is empty and a successful fetch occurs, inst_valid=1 with inst_out=mem_data_out and inst_pc=pc in the same cycle.
  - If inst_ready is also 1 that cycle, the word is consumed and not enqueued.
  - Latency becomes 0 cycles.
- Undefined: no bypass; latency is fixed at 1 cycle.

Decomposition:
- Package if_pkg contains:
  - typedef enum logic [1:0] {RUN, HALTED, ERR} fetch_state_t;
  - typedef struct packed {logic [15:0] inst; logic [15:0] pc;} fetch_entry_t;
  - constant INST_W=16 and constant PC_STEP=2.
- Sub-module if_inst_queue:
  - Circular FIFO of fetch_entry_t with head/tail pointers and a count.
  - Inputs: enq, deq, flush.
  - Outputs: full, empty, head.
  - Parameter: QDEPTH.

Test Plan:
- Reset, memory preloaded with 0x1111, 0x2222, 0x3333 at 0x0000, 0x0002, 0x0004, inst_ready=1 -> addresses 0,2,4 issued on consecutive cycles; inst_out 0x1111, 0x2222, 0x3333 in order, one cycle behind each fetch; mem_wr=0 throughout.
- inst_ready=0 for 5 cycles -> exactly QDEPTH fetches, then mem_enable=0 and pc frozen; inst_ready=1 -> drain in order and fetching resumes with no gaps.
- Redirect to 0x00F0 while the queue is full -> queue empty next cycle; next fetch addr=0x00F0; no stale words delivered.
- Redirect to 0x0013 -> mem_err=1, fetch_err=1, fetch_err_pc=0x0013, state ERR, no further fetches; redirect to 0x0020 clears fetch_err and fetching resumes.
- pc=0xFFFE fetch -> next mem_addr=0x0000; halt=1 -> mem_enable stays 0 until a redirect.
- rst pulsed low mid-stream with the queue half full -> outputs go to reset values asynchronously; fetching restarts at RESET_PC after release.

Source files
------------

// File: rtl/if_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package if_pkg;

  localparam int          INST_W  = 16;
  localparam logic [15:0] PC_STEP = 16'd2;

  typedef enum logic [1:0] {RUN, HALTED, ERR} fetch_state_t;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [15:0]       pc;
  } fetch_entry_t;

  // Sequential PC; wraps modulo 2^16.
  function automatic logic [15:0] next_pc(input logic [15:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// Read port of the 16-bit big-endian fetch memory.
interface if_fetch_ctrl_if;
  logic [15:0] mem_addr;
  logic        mem_enable;
  logic        mem_wr;
  logic [15:0] mem_data_in;
  logic [15:0] mem_data_out;
  logic        mem_err;

  modport master (
    output mem_addr, mem_enable, mem_wr, mem_data_in,
    input  mem_data_out, mem_err
  );

  modport slave (
    input  mem_addr, mem_enable, mem_wr, mem_data_in,
    output mem_data_out, mem_err
  );
endinterface

// File: rtl/if_fetch_ctrl_inst_queue.sv
// Circular FIFO of fetched {inst, pc} entries; QDEPTH must be a power of two >= 2.
module if_inst_queue
  import if_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enq,
  input  logic         deq,
  input  logic         flush,
  input  fetch_entry_t wr_entry,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH + 1);

  fetch_entry_t   mem [QDEPTH];
  logic [PW-1:0]  hd_q, tl_q;
  logic [CW-1:0]  cnt_q;
  logic           do_enq, do_deq;

  assign full   = (cnt_q == CW'(QDEPTH));
  assign empty  = (cnt_q == '0);
  // Enqueue into a full queue is only legal when the head leaves the same edge.
  assign do_deq = deq && !empty;
  assign do_enq = enq && (!full || do_deq);
  assign head   = mem[hd_q];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hd_q  <= '0;
      tl_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      hd_q  <= '0;
      tl_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_enq) tl_q <= tl_q + PW'(1);
      if (do_deq) hd_q <= hd_q + PW'(1);
      case ({do_enq, do_deq})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_enq && !flush) mem[tl_q] <= wr_entry;
  end

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch initiator: PC, one aligned read per cycle, queue to decode.
// Optional same-cycle bypass of an empty queue under `IF_BYPASS_EN.
module if_fetch_ctrl
  import if_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          QDEPTH   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                redirect_valid,
  input  logic [15:0]         redirect_pc,
  input  logic                halt,
  input  logic                inst_ready,
  output logic                inst_valid,
  output logic [INST_W-1:0]   inst_out,
  output logic [15:0]         inst_pc,
  output logic                fetch_err,
  output logic [15:0]         fetch_err_pc,
  if_fetch_ctrl_if.master     mem
);

  fetch_state_t state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic         err_q, err_d;
  logic [15:0]  err_pc_q, err_pc_d;

  logic         q_full, q_empty, q_enq, q_deq;
  fetch_entry_t q_head, q_wr;
  logic         slot, fetch, fetch_ok, fault, byp;

  // Full queue only has a slot when its head is consumed this cycle.
  assign slot     = !q_full || (inst_ready && !q_empty);
  assign fetch    = rst && (state_q == RUN) && !redirect_valid && slot;
  assign fetch_ok = fetch && !mem.mem_err;
  assign fault    = fetch && mem.mem_err;

`ifdef IF_BYPASS_EN
  assign byp = q_empty && fetch_ok;
`else
  assign byp = 1'b0;
`endif

  assign mem.mem_enable  = fetch;
  assign mem.mem_addr    = pc_q;
  assign mem.mem_wr      = 1'b0;
  assign mem.mem_data_in = '0;

  assign q_wr  = '{inst: mem.mem_data_out, pc: pc_q};
  assign q_enq = fetch_ok && !(byp && inst_ready);
  assign q_deq = inst_ready && !q_empty && !redirect_valid;

  if_inst_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk      (clk),
    .rst      (rst),
    .enq      (q_enq),
    .deq      (q_deq),
    .flush    (redirect_valid),
    .wr_entry (q_wr),
    .full     (q_full),
    .empty    (q_empty),
    .head     (q_head)
  );

  assign inst_valid = !q_empty || byp;

  always_comb begin
    inst_out = '0;
    inst_pc  = '0;
    if (!q_empty) begin
      inst_out = q_head.inst;
      inst_pc  = q_head.pc;
    end else if (byp) begin
      inst_out = mem.mem_data_out;
      inst_pc  = pc_q;
    end
  end

  assign fetch_err    = err_q;
  assign fetch_err_pc = err_pc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      err_q    <= 1'b0;
      err_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      err_q    <= err_d;
      err_pc_q <= err_pc_d;
    end
  end

  // Redirect wins over everything; a fault wins over a same-cycle halt.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    err_d    = err_q;
    err_pc_d = err_pc_q;
    if (redirect_valid) begin
      state_d = RUN;
      pc_d    = redirect_pc;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (fault) begin
            state_d  = ERR;
            err_d    = 1'b1;
            err_pc_d = pc_q;
          end else begin
            if (fetch_ok) pc_d = next_pc(pc_q);
            if (halt)     state_d = HALTED;
          end
        end
        HALTED:  state_d = HALTED;
        ERR:     state_d = ERR;
        default: state_d = RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl (default build, QDEPTH=2, RESET_PC=0).
module tb_if_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        halt;
  logic        inst_ready;
  logic        inst_valid;
  logic [15:0] inst_out;
  logic [15:0] inst_pc;
  logic        fetch_err;
  logic [15:0] fetch_err_pc;

  int n_vec = 0;
  int n_bad = 0;
  int fetches;

  if_fetch_ctrl_if mbus ();

  always #5 clk = ~clk;

  if_fetch_ctrl #(.RESET_PC(16'h0000), .QDEPTH(2)) u_dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .inst_ready     (inst_ready),
    .inst_valid     (inst_valid),
    .inst_out       (inst_out),
    .inst_pc        (inst_pc),
    .fetch_err      (fetch_err),
    .fetch_err_pc   (fetch_err_pc),
    .mem            (mbus)
  );

  // Memory model: three preloaded words, elsewhere addr ^ 0xC000.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0000: return 16'h1111;
      16'h0002: return 16'h2222;
      16'h0004: return 16'h3333;
      default:  return a ^ 16'hC000;
    endcase
  endfunction

  assign mbus.mem_data_out = mem_word(mbus.mem_addr);
  assign mbus.mem_err      = mbus.mem_enable & mbus.mem_addr[0];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0; inst_ready = 1'b1;
    #2;
    chk("rst_valid", inst_valid, 0);
    chk("rst_out", inst_out, 0);
    chk("rst_pc", inst_pc, 0);
    chk("rst_err", fetch_err, 0);
    chk("rst_errpc", fetch_err_pc, 0);
    chk("rst_en", mbus.mem_enable, 0);
    chk("rst_wr", mbus.mem_wr, 0);
    chk("rst_wdata", mbus.mem_data_in, 0);

    // Streaming from reset
    cyc(); rst = 1'b1; #1;
    chk("a0_en", mbus.mem_enable, 1); chk("a0_addr", mbus.mem_addr, 16'h0000);
    chk("a0_valid", inst_valid, 0);
    cyc(); #1;
    chk("a1_addr", mbus.mem_addr, 16'h0002); chk("a1_out", inst_out, 16'h1111);
    chk("a1_pc", inst_pc, 16'h0000); chk("a1_wr", mbus.mem_wr, 0);
    cyc(); #1;
    chk("a2_addr", mbus.mem_addr, 16'h0004); chk("a2_out", inst_out, 16'h2222);
    cyc(); #1;
    chk("a3_addr", mbus.mem_addr, 16'h0006); chk("a3_out", inst_out, 16'h3333);
    chk("a3_pc", inst_pc, 16'h0004); chk("a3_wr", mbus.mem_wr, 0);

    // Back-pressure: redirect to 0x10 empties the queue, then stall 5 cycles
    cyc(); redirect_valid = 1'b1; redirect_pc = 16'h0010; inst_ready = 1'b0; #1;
    chk("r_en", mbus.mem_enable, 0);
    cyc(); redirect_valid = 1'b0; #1;
    fetches = 0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin cyc(); #1; end
      if (mbus.mem_enable) fetches++;
    end
    chk("stall_fetches", fetches, 2);
    chk("stall_en", mbus.mem_enable, 0);
    chk("stall_addr", mbus.mem_addr, 16'h0014);
    chk("stall_out", inst_out, 16'hC010);
    chk("stall_pc", inst_pc, 16'h0010);
    cyc(); inst_ready = 1'b1; #1;
    chk("d0_en", mbus.mem_enable, 1); chk("d0_addr", mbus.mem_addr, 16'h0014);
    chk("d0_out", inst_out, 16'hC010);
    cyc(); #1;
    chk("d1_out", inst_out, 16'hC012); chk("d1_addr", mbus.mem_addr, 16'h0016);
    cyc(); #1;
    chk("d2_out", inst_out, 16'hC014); chk("d2_addr", mbus.mem_addr, 16'h0018);

    // Redirect while full discards queued words
    cyc(); inst_ready = 1'b0; #1;
    chk("f0_en", mbus.mem_enable, 0);
    cyc(); redirect_valid = 1'b1; redirect_pc = 16'h00F0; inst_ready = 1'b1; #1;
    chk("f1_en", mbus.mem_enable, 0);
    cyc(); redirect_valid = 1'b0; #1;
    chk("g0_valid", inst_valid, 0); chk("g0_out", inst_out, 0);
    chk("g0_addr", mbus.mem_addr, 16'h00F0); chk("g0_en", mbus.mem_enable, 1);
    cyc(); #1;
    chk("g1_out", inst_out, 16'hC0F0); chk("g1_pc", inst_pc, 16'h00F0);

    // Misaligned redirect faults
    cyc(); redirect_valid = 1'b1; redirect_pc = 16'h0013; #1;
    cyc(); redirect_valid = 1'b0; #1;
    chk("e0_en", mbus.mem_enable, 1); chk("e0_merr", mbus.mem_err, 1);
    chk("e0_valid", inst_valid, 0);
    cyc(); #1;
    chk("e1_err", fetch_err, 1); chk("e1_errpc", fetch_err_pc, 16'h0013);
    chk("e1_en", mbus.mem_enable, 0); chk("e1_valid", inst_valid, 0);
    cyc(); #1;
    chk("e2_en", mbus.mem_enable, 0); chk("e2_err", fetch_err, 1);
    cyc(); redirect_valid = 1'b1; redirect_pc = 16'h0020; #1;
    cyc(); redirect_valid = 1'b0; #1;
    chk("e3_err", fetch_err, 0); chk("e3_errpc", fetch_err_pc, 16'h0013);
    chk("e3_en", mbus.mem_enable, 1); chk("e3_addr", mbus.mem_addr, 16'h0020);

    // PC wrap then halt
    cyc(); redirect_valid = 1'b1; redirect_pc = 16'hFFFC; #1;
    cyc(); redirect_valid = 1'b0; #1;
    chk("w0_addr", mbus.mem_addr, 16'hFFFC);
    cyc(); #1;
    chk("w1_addr", mbus.mem_addr, 16'hFFFE); chk("w1_out", inst_out, 16'h3FFC);
    cyc(); #1;
    chk("w2_addr", mbus.mem_addr, 16'h0000); chk("w2_out", inst_out, 16'h3FFE);
    chk("w2_pc", inst_pc, 16'hFFFE);
    cyc(); halt = 1'b1; #1;
    chk("w3_en", mbus.mem_enable, 1); chk("w3_addr", mbus.mem_addr, 16'h0002);
    chk("w3_out", inst_out, 16'h1111);
    cyc(); halt = 1'b0; #1;
    chk("h0_en", mbus.mem_enable, 0); chk("h0_out", inst_out, 16'h2222);
    cyc(); #1;
    chk("h1_en", mbus.mem_enable, 0); chk("h1_valid", inst_valid, 0);
    chk("h1_out", inst_out, 0);
    cyc(); #1;
    chk("h2_en", mbus.mem_enable, 0);

    // Restart, then asynchronous reset with the queue half full
    cyc(); redirect_valid = 1'b1; redirect_pc = 16'h0000; #1;
    cyc(); redirect_valid = 1'b0; #1;
    chk("s0_addr", mbus.mem_addr, 16'h0000); chk("s0_en", mbus.mem_enable, 1);
    cyc(); #1;
    chk("s1_out", inst_out, 16'h1111);
    cyc(); inst_ready = 1'b0; #1;
    chk("s2_out", inst_out, 16'h2222); chk("s2_addr", mbus.mem_addr, 16'h0004);
    #2; rst = 1'b0; #1;
    chk("ar_valid", inst_valid, 0); chk("ar_out", inst_out, 0);
    chk("ar_pc", inst_pc, 0); chk("ar_en", mbus.mem_enable, 0);
    chk("ar_addr", mbus.mem_addr, 16'h0000);
    cyc(); rst = 1'b1; inst_ready = 1'b1; #1;
    chk("x0_en", mbus.mem_enable, 1); chk("x0_addr", mbus.mem_addr, 16'h0000);
    chk("x0_valid", inst_valid, 0);
    cyc(); #1;
    chk("x1_out", inst_out, 16'h1111); chk("x1_addr", mbus.mem_addr, 16'h0002);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
